bcd_display_scanner: RTL and testbench

Time-multiplexed scan controller for a common-anode multi-digit 7-segment display. It sits directly upstream of the BCD-to-7-segment decoder. It holds a double-buffered set of BCD digits and presents one digit at a time on bcd_out, which the decoder turns into segments. It also drives the matching active-low anode enable.
- Digit updates take effect only at frame boundaries, so the display never shows a torn value.

---
 rtl/bcd_display_scanner_if.sv | 33 +++
 rtl/bcd_display_scanner.sv | 145 ++++++++++++++
 tb/tb_bcd_display_scanner.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_display_scanner_if.sv
// ---------------------------------------------------------------------------
// bcd_display_scanner_if
// Bundles the control, digit-load and display-drive signals of the
// 7-segment scan controller.
//   en         : scan enable (low = blank display, freeze scan)
//   load       : one-cycle strobe capturing digits_in
//   digits_in  : packed BCD, digit 0 in bits [3:0]
//   bcd_out    : nibble for the BCD-to-7-segment decoder (4'hF = blank)
//   an_n       : active-low anode enables, bit i = digit i
//   frame_tick : one-cycle pulse when the scan wraps to digit 0
// Modports: master drives en/load/digits_in, slave (the scanner) drives
// the display outputs.
// ---------------------------------------------------------------------------
interface bcd_display_scanner_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic                      en;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   digits_in;
    logic [3:0]                bcd_out;
    logic [NUM_DIGITS-1:0]     an_n;
    logic                      frame_tick;

    modport master (
        output en, load, digits_in,
        input  bcd_out, an_n, frame_tick
    );

    modport slave (
        input  en, load, digits_in,
        output bcd_out, an_n, frame_tick
    );
endinterface

// File: rtl/bcd_display_scanner.sv
// ---------------------------------------------------------------------------
// bcd_display_scanner
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment
// display. Digits are double-buffered (staging -> display) and the display
// copy only changes at a frame wrap, so a frame never shows a torn value.
// Ports:
//   clk  : system clock
//   rst  : asynchronous, active-high reset
//   bus  : bcd_display_scanner_if.slave (en, load, digits_in in;
//          bcd_out, an_n, frame_tick out, all outputs registered)
// Parameters:
//   NUM_DIGITS : number of digits (2..8)
//   PRESCALE   : clk cycles each digit stays lit (>= 2)
// Optional feature (macro LEADING_ZERO_BLANK_EN): zero digits above the most
// significant nonzero digit are blanked (bcd_out = 4'hF, anode off); digit 0
// is never blanked.
// ---------------------------------------------------------------------------
module bcd_display_scanner #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned PRESCALE   = 50000
) (
    input  logic                   clk,
    input  logic                   rst,
    bcd_display_scanner_if.slave   bus
);
    localparam int unsigned CNT_W = (PRESCALE   > 2) ? $clog2(PRESCALE)   : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

    logic [CNT_W-1:0]                r_cnt;
    logic [IDX_W-1:0]                r_idx;
    logic                            r_pending;
    logic [NUM_DIGITS-1:0][3:0]      r_staging;
    logic [NUM_DIGITS-1:0][3:0]      r_display;
    logic [3:0]                      r_bcd_out;
    logic [NUM_DIGITS-1:0]           r_an_n;
    logic                            r_frame_tick;

    logic [NUM_DIGITS-1:0][3:0]      w_digits_in;
    logic                            w_tick;
    logic                            w_wrap;
    logic                            w_blank_cur;
    logic [CNT_W-1:0]                w_cnt_nxt;
    logic [IDX_W-1:0]                w_idx_nxt;
    logic                            w_pending_nxt;
    logic [NUM_DIGITS-1:0][3:0]      w_staging_nxt;
    logic [NUM_DIGITS-1:0][3:0]      w_display_nxt;
    logic [3:0]                      w_bcd_nxt;
    logic [NUM_DIGITS-1:0]           w_an_n_nxt;

    assign w_digits_in = bus.digits_in;

    // Prescaler terminal count and frame wrap; both gated by en so a frozen
    // scan never transfers the staging buffer.
    assign w_tick = bus.en && (r_cnt == CNT_W'(PRESCALE - 1));
    assign w_wrap = w_tick && (r_idx == IDX_W'(NUM_DIGITS - 1));

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] w_blank;
    logic                  w_seen_nz;

    // Walk down from the top digit; a digit is blank while no nonzero digit
    // has been seen at or above it. Digit 0 always shows.
    always_comb begin
        w_blank   = '0;
        w_seen_nz = 1'b0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
            w_seen_nz  = w_seen_nz | (r_display[i] != 4'h0);
            w_blank[i] = ~w_seen_nz;
        end
    end

    assign w_blank_cur = w_blank[r_idx];
`else
    assign w_blank_cur = 1'b0;
`endif

    // Next-state: scan position, double buffer and registered display drive.
    always_comb begin
        w_cnt_nxt     = r_cnt;
        w_idx_nxt     = r_idx;
        w_pending_nxt = r_pending;
        w_staging_nxt = r_staging;
        w_display_nxt = r_display;
        w_bcd_nxt     = 4'hF;
        w_an_n_nxt    = '1;

        if (bus.en) begin
            if (w_tick) begin
                w_cnt_nxt = '0;
                w_idx_nxt = w_wrap ? '0 : r_idx + IDX_W'(1);
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end

        if (bus.load) begin
            w_staging_nxt = w_digits_in;
        end

        // A load coinciding with the wrap bypasses staging so it shows in
        // the very next frame; otherwise the wrap drains a pending load.
        if (w_wrap && bus.load) begin
            w_display_nxt = w_digits_in;
            w_pending_nxt = 1'b0;
        end else if (w_wrap && r_pending) begin
            w_display_nxt = r_staging;
            w_pending_nxt = 1'b0;
        end else if (bus.load) begin
            w_pending_nxt = 1'b1;
        end

        if (bus.en && !w_blank_cur) begin
            w_bcd_nxt  = r_display[r_idx];
            w_an_n_nxt = ~(NUM_DIGITS'(1) << r_idx);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_pending    <= 1'b0;
            r_staging    <= {NUM_DIGITS{4'hF}};
            r_display    <= {NUM_DIGITS{4'hF}};
            r_bcd_out    <= 4'hF;
            r_an_n       <= '1;
            r_frame_tick <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_pending    <= w_pending_nxt;
            r_staging    <= w_staging_nxt;
            r_display    <= w_display_nxt;
            r_bcd_out    <= w_bcd_nxt;
            r_an_n       <= w_an_n_nxt;
            r_frame_tick <= w_wrap;
        end
    end

    assign bus.bcd_out    = r_bcd_out;
    assign bus.an_n       = r_an_n;
    assign bus.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// ---------------------------------------------------------------------------
// tb_bcd_display_scanner
// Self-checking bench for bcd_display_scanner (NUM_DIGITS=4, PRESCALE=4).
// A reference model tracks the scan as a single frame phase (0..15) plus
// the displayed digits and the latest pending load. Honours
// LEADING_ZERO_BLANK_EN when defined.
// ---------------------------------------------------------------------------
module tb_bcd_display_scanner;
    localparam int unsigned ND    = 4;
    localparam int unsigned PS    = 4;
    localparam int unsigned FRAME = ND * PS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bcd_display_scanner_if #(.NUM_DIGITS(ND)) bus ();

    bcd_display_scanner #(.NUM_DIGITS(ND), .PRESCALE(PS)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          m_phase;
    logic [3:0]  m_disp [ND];
    logic [15:0] m_stage;
    bit          m_pend;
    logic [3:0]  m_bcd;
    logic [3:0]  m_an;
    logic        m_ft;

    typedef struct {
        logic        en;
        logic        load;
        logic [15:0] din;
        logic [3:0]  bcd;
        logic [3:0]  an;
        logic        ft;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        for (int i = 0; i < ND; i++) m_disp[i] = 4'hF;
        m_stage = 16'hFFFF;
        m_pend  = 0;
        m_bcd   = 4'hF;
        m_an    = 4'hF;
        m_ft    = 1'b0;
    endtask

    // One clock of the model: outputs come from the pre-edge scan position.
    task automatic model_step(input logic e, input logic l, input logic [15:0] d);
        int dig;
        int msd;
        bit wrap;
        bit lzb;
`ifdef LEADING_ZERO_BLANK_EN
        lzb = 1;
`else
        lzb = 0;
`endif
        dig  = m_phase / PS;
        wrap = e && (m_phase == FRAME - 1);
        msd  = 0;
        for (int i = 0; i < ND; i++) if (m_disp[i] != 4'h0) msd = i;
        if (e && !(lzb && dig > msd)) begin
            m_bcd      = m_disp[dig];
            m_an       = 4'hF;
            m_an[dig]  = 1'b0;
        end else begin
            m_bcd = 4'hF;
            m_an  = 4'hF;
        end
        m_ft = wrap;
        if (wrap && l) begin
            for (int i = 0; i < ND; i++) m_disp[i] = d[4*i +: 4];
            m_pend = 0;
        end else if (wrap && m_pend) begin
            for (int i = 0; i < ND; i++) m_disp[i] = m_stage[4*i +: 4];
            m_pend = 0;
        end else if (l) begin
            m_pend = 1;
        end
        if (l) m_stage = d;
        if (e) m_phase = (m_phase + 1) % FRAME;
    endtask

    task automatic step(input logic e, input logic l, input logic [15:0] d);
        @(negedge clk);
        bus.en        = e;
        bus.load      = l;
        bus.digits_in = d;
        @(posedge clk);
        model_step(e, l, d);
        #1;
    endtask

    task automatic step_chk(input logic e, input logic l, input logic [15:0] d);
        step(e, l, d);
        check("model_bcd", 16'(bus.bcd_out), 16'(m_bcd));
        check("model_an",  16'(bus.an_n),    16'(m_an));
        check("model_ft",  16'(bus.frame_tick), 16'(m_ft));
    endtask

    // Scan with en=1 until frame_tick, optionally requiring blank bcd_out.
    task automatic run_to_frame(input int budget, input bit chk_blank);
        bit seen;
        seen = 0;
        for (int k = 0; k < budget && !seen; k++) begin
            step_chk(1'b1, 1'b0, 16'h0);
            if (chk_blank) check("pre_frame_blank", 16'(bus.bcd_out), 16'hF);
            seen = bus.frame_tick;
        end
        check("frame_tick_seen", 16'(seen), 16'h1);
    endtask

    // One full frame: per-digit expected nibble and anode pattern.
    task automatic expect_frame2(input logic [15:0] bcds, input logic [15:0] ans);
        int dg;
        for (int j = 0; j < FRAME; j++) begin
            step_chk(1'b1, 1'b0, 16'h0);
            dg = j / PS;
            check("frame_bcd", 16'(bus.bcd_out), 16'(bcds[4*dg +: 4]));
            check("frame_an",  16'(bus.an_n),    16'(ans[4*dg +: 4]));
        end
    endtask

    task automatic expect_frame(input logic [15:0] val);
        expect_frame2(val, 16'h7BDE);
    endtask

    task automatic advance_to_phase(input int ph);
        for (int k = 0; k < 2 * FRAME && m_phase != ph; k++) step_chk(1'b1, 1'b0, 16'h0);
        check("phase_reached", 16'(m_phase), 16'(ph));
    endtask

    initial begin
        logic [3:0] an_pat [4];
        logic [15:0] d;
        logic e, l;
        an_pat = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        for (int k = 0; k < 17; k++)
            vecs[k] = '{en: 1'b1, load: 1'b0, din: 16'h0, bcd: 4'hF,
                        an: an_pat[(k / 4) % 4], ft: (k == 15)};

        rst = 1'b1;
        bus.en = 1'b0;
        bus.load = 1'b0;
        bus.digits_in = '0;
        model_reset();
        #1;
        check("reset_bcd", 16'(bus.bcd_out), 16'hF);
        check("reset_an",  16'(bus.an_n),    16'hF);
        check("reset_ft",  16'(bus.frame_tick), 16'h0);
        @(negedge clk);
        rst = 1'b0;

        // Empty display scan from reset
        for (int k = 0; k < 17; k++) begin
            step(vecs[k].en, vecs[k].load, vecs[k].din);
            check("tbl_bcd", 16'(bus.bcd_out), 16'(vecs[k].bcd));
            check("tbl_an",  16'(bus.an_n),    16'(vecs[k].an));
            check("tbl_ft",  16'(bus.frame_tick), 16'(vecs[k].ft));
        end

        // Mid-frame load shows only after the wrap
        step_chk(1'b1, 1'b1, 16'h1234);
        run_to_frame(40, 1'b1);
        expect_frame(16'h1234);

        // Last load before the wrap wins
        step_chk(1'b1, 1'b1, 16'h1111);
        step_chk(1'b1, 1'b0, 16'h0);
        step_chk(1'b1, 1'b1, 16'h9876);
        run_to_frame(40, 1'b0);
        expect_frame(16'h9876);

        // Load coinciding with the wrap tick
        advance_to_phase(FRAME - 1);
        step_chk(1'b1, 1'b1, 16'h0505);
        check("wrap_load_ft", 16'(bus.frame_tick), 16'h1);
        step_chk(1'b1, 1'b0, 16'h0);
        check("wrap_load_d0_bcd", 16'(bus.bcd_out), 16'h5);
        check("wrap_load_d0_an",  16'(bus.an_n),    16'hE);

        // en low during digit 2, then resume the remaining count
        advance_to_phase(2 * PS + 1);
        for (int k = 0; k < 10; k++) begin
            step_chk(1'b0, 1'b0, 16'h0);
            check("freeze_an",  16'(bus.an_n),    16'hF);
            check("freeze_bcd", 16'(bus.bcd_out), 16'hF);
        end
        for (int k = 0; k < 3; k++) begin
            step_chk(1'b1, 1'b0, 16'h0);
            check("resume_d2_an", 16'(bus.an_n), 16'hB);
        end
        step_chk(1'b1, 1'b0, 16'h0);
`ifdef LEADING_ZERO_BLANK_EN
        check("resume_d3_an", 16'(bus.an_n), 16'hF);
`else
        check("resume_d3_an", 16'(bus.an_n), 16'h7);
`endif

        // Asynchronous reset mid-frame discards a pending load
        step_chk(1'b1, 1'b1, 16'hAAAA);
        step_chk(1'b1, 1'b0, 16'h0);
        @(negedge clk);
        bus.en = 1'b0;
        bus.load = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_an",  16'(bus.an_n),    16'hF);
        check("async_rst_bcd", 16'(bus.bcd_out), 16'hF);
        check("async_rst_ft",  16'(bus.frame_tick), 16'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        run_to_frame(40, 1'b1);
        expect_frame(16'hFFFF);

`ifdef LEADING_ZERO_BLANK_EN
        step_chk(1'b1, 1'b1, 16'h0070);
        run_to_frame(40, 1'b0);
        expect_frame2(16'hFF70, 16'hFFDE);
        step_chk(1'b1, 1'b1, 16'h0000);
        run_to_frame(40, 1'b0);
        expect_frame2(16'hFFF0, 16'hFFFE);
`endif

        // Randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            e = ($urandom_range(0, 9) != 0);
            l = ($urandom_range(0, 7) == 0);
            d = 16'($urandom);
            if ($urandom_range(0, 2) == 0) d = d & 16'h00FF;
            if ($urandom_range(0, 5) == 0) d = d & 16'h000F;
            step_chk(e, l, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
